// File: rtl/siso_frame_pkg.sv
// Shared types and default constants for the serial frame deserializer.
package siso_frame_pkg;
    typedef enum logic {HUNT, LOCK} state_t;

    localparam int         WIDTH_DEFAULT       = 8;
    localparam logic [7:0] SYNC_DEFAULT        = 8'hA5;
    localparam int         FRAME_WORDS_DEFAULT = 4;
endpackage

// File: rtl/siso_frame_deserializer_if.sv
// Serial-in / word-out bundle between the shift stage, the deserializer and word logic.
interface siso_frame_deserializer_if #(parameter int WIDTH = 8);
    logic             I;
    logic             I_VALID;
    logic [WIDTH-1:0] O;
    logic             O_VALID;
    logic             SOF;
    logic             LOCKED;

    modport master (output I, I_VALID, input  O, O_VALID, SOF, LOCKED);
    modport slave  (input  I, I_VALID, output O, O_VALID, SOF, LOCKED);
endinterface

// File: rtl/sipo_shift_reg.sv
// WIDTH-bit serial-in/parallel-out register, first-received bit ends in the MSB.
// qNext is the value the register takes on an enabled edge, so callers can act on it that edge.
module sipo_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] qNext
);
    logic [WIDTH-1:0] q;

    assign qNext = {q[WIDTH-2:0], din};

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET)
            q <= '0;
        else if (en)
            q <= qNext;
    end
endmodule

// File: rtl/siso_frame_deserializer.sv
// Hunts for SYNC in a serial stream, then emits FRAME_WORDS words of WIDTH bits, MSB first.
// Outputs are registered; a lost I_VALID pauses everything, it never aborts a frame.
module siso_frame_deserializer
    import siso_frame_pkg::*;
#(
    parameter int               WIDTH       = WIDTH_DEFAULT,
    parameter logic [WIDTH-1:0] SYNC        = WIDTH'(SYNC_DEFAULT),
    parameter int               FRAME_WORDS = FRAME_WORDS_DEFAULT
) (
    input logic                      CLK,
    input logic                      ASYNCRESET,
    siso_frame_deserializer_if.slave bus
);
    localparam int FILL_W = $clog2(WIDTH + 1);
    localparam int BIT_W  = $clog2(WIDTH);
    localparam int WORD_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

    localparam logic [FILL_W-1:0] FILL_MAX  = FILL_W'(WIDTH);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(FRAME_WORDS - 1);

    state_t             state, stateN;
    logic [FILL_W-1:0]  fill, fillN, fillInc;
    logic [BIT_W-1:0]   bitCnt, bitCntN;
    logic [WORD_W-1:0]  wordCnt, wordCntN;
    logic [WIDTH-1:0]   srNext;
    logic [WIDTH-1:0]   oReg, oRegN;
    logic               oValid, oValidN;
    logic               sof, sofN;
    logic               locked;

    sipo_shift_reg #(.WIDTH(WIDTH)) uSr (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .en         (bus.I_VALID),
        .din        (bus.I),
        .qNext      (srNext)
    );

    always_comb begin
        stateN   = state;
        fillN    = fill;
        bitCntN  = bitCnt;
        wordCntN = wordCnt;
        oRegN    = oReg;
        oValidN  = 1'b0;
        sofN     = 1'b0;
        fillInc  = (fill == FILL_MAX) ? fill : fill + 1'b1;

        if (bus.I_VALID) begin
            unique case (state)
                HUNT: begin
                    fillN = fillInc;
                    // fill guards against matching stale bits left over from the previous frame
                    if (srNext == SYNC && fillInc >= FILL_MAX) begin
                        stateN   = LOCK;
                        bitCntN  = '0;
                        wordCntN = '0;
                    end
                end
                LOCK: begin
                    if (bitCnt == BIT_LAST) begin
                        oRegN   = srNext;
                        oValidN = 1'b1;
                        sofN    = (wordCnt == '0);
                        bitCntN = '0;
                        if (wordCnt == WORD_LAST) begin
                            stateN   = HUNT;
                            fillN    = '0;
                            wordCntN = '0;
                        end else begin
                            wordCntN = wordCnt + 1'b1;
                        end
                    end else begin
                        bitCntN = bitCnt + 1'b1;
                    end
                end
                default: stateN = HUNT;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state   <= HUNT;
            fill    <= '0;
            bitCnt  <= '0;
            wordCnt <= '0;
            oReg    <= '0;
            oValid  <= 1'b0;
            sof     <= 1'b0;
            locked  <= 1'b0;
        end else begin
            state   <= stateN;
            fill    <= fillN;
            bitCnt  <= bitCntN;
            wordCnt <= wordCntN;
            oReg    <= oRegN;
            oValid  <= oValidN;
            sof     <= sofN;
            locked  <= (stateN == LOCK);
        end
    end

    assign bus.O       = oReg;
    assign bus.O_VALID = oValid;
    assign bus.SOF     = sof;
    assign bus.LOCKED  = locked;
endmodule
